// File: rtl/avmm_rr_arbiter.sv
// Purpose : N-master -> 1-slave Avalon-MM round-robin arbiter with pipelined read-return routing.
// Latency : request -> slave accept in 2 cycles (one arbitration bubble); read return strobe is combinational.
// Backpres: non-granted masters see waitrequest=1; the granted master sees s_waitrequest; reads block when MAX_PENDING are outstanding.
//
// Ports:
//   clk_clk, reset_reset_n                 clock, async active-low reset
//   m_address/m_read/m_write/m_writedata/
//   m_byteenable/m_waitrequest             packed per-master Avalon-MM slave-side ports
//   m_readdata, m_readdatavalid            shared read data, one-hot return strobe
//   s_*                                    master-side port toward the SDRAM controller
//   rsp_err                                sticky: read data returned with no outstanding read
//   grant_cnt                              per-master 16-bit accepted-transaction counters
// Build option: define ARB_STATS_EN to enable grant_cnt counters; otherwise grant_cnt reads 0.
module avmm_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                                clk_clk,
  input  logic                                reset_reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]       m_address,
  input  logic [NUM_MASTERS-1:0]              m_read,
  input  logic [NUM_MASTERS-1:0]              m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]       m_writedata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   m_byteenable,
  output logic [NUM_MASTERS-1:0]              m_waitrequest,
  output logic [DATA_W-1:0]                   m_readdata,
  output logic [NUM_MASTERS-1:0]              m_readdatavalid,
  output logic [ADDR_W-1:0]                   s_address,
  output logic                                s_read,
  output logic                                s_write,
  output logic [DATA_W-1:0]                   s_writedata,
  output logic [(DATA_W/8)-1:0]               s_byteenable,
  input  logic                                s_waitrequest,
  input  logic [DATA_W-1:0]                   s_readdata,
  input  logic                                s_readdatavalid,
  output logic                                rsp_err,
  output logic [NUM_MASTERS*16-1:0]           grant_cnt
);

  localparam int BE_W   = DATA_W / 8;
  localparam int TAG_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int FPTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e             state_q;
  logic [TAG_W-1:0]   grant_q;
  logic [TAG_W-1:0]   rr_ptr_q;

  // Tag FIFO: remembers which master issued each outstanding read.
  logic [TAG_W-1:0]   fifo_mem_q [MAX_PENDING];
  logic [FPTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic               rsp_err_q;

  logic               can_read;
  logic [NUM_MASTERS-1:0] eligible;
  logic               win_vld;
  logic [TAG_W-1:0]   win_idx;
  logic [TAG_W-1:0]   win_next;
  logic               busy;
  logic               g_read, g_write, g_req;
  logic               accept, push, pop;
  logic [TAG_W-1:0]   fifo_head;

  assign can_read = (fifo_cnt_q < CNT_W'(MAX_PENDING));

  // A master asserting both read and write is treated as a read, so it is
  // blocked when the tag FIFO is full even though a write would fit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = m_read[i] ? can_read : m_write[i];
    end
  end

  // First eligible master at or after the round-robin pointer, with wrap.
  always_comb begin
    int cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = TAG_W'(cand);
      end
    end
  end

  assign win_next = (win_idx == TAG_W'(NUM_MASTERS - 1)) ? '0 : win_idx + TAG_W'(1);

  assign busy    = (state_q == S_BUSY);
  assign g_read  = m_read[grant_q];
  assign g_write = m_write[grant_q] & ~g_read;
  assign g_req   = g_read | g_write;
  assign accept  = busy & g_req & ~s_waitrequest;
  assign push    = accept & g_read;
  assign pop     = s_readdatavalid & (fifo_cnt_q != '0);

  // Arbitration FSM. A granted master that drops its request releases the
  // slot without a transfer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            grant_q  <= win_idx;
            rr_ptr_q <= win_next;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!g_req || !s_waitrequest) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Slave-side mux: only the granted master's fields reach the slave.
  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    if (busy) begin
      s_address    = m_address[grant_q*ADDR_W +: ADDR_W];
      s_writedata  = m_writedata[grant_q*DATA_W +: DATA_W];
      s_byteenable = m_byteenable[grant_q*BE_W +: BE_W];
      s_read       = g_read;
      s_write      = g_write;
    end
  end

  always_comb begin
    m_waitrequest = '1;
    if (busy) m_waitrequest[grant_q] = s_waitrequest;
  end

  assign fifo_head = fifo_mem_q[rd_ptr_q];

  always_comb begin
    m_readdatavalid = '0;
    if (pop) m_readdatavalid[fifo_head] = 1'b1;
  end

  assign m_readdata = s_readdata;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Tag storage needs no reset: the count and pointers define validity.
  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= grant_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= (wr_ptr_q == FPTR_W'(MAX_PENDING - 1)) ? '0 : wr_ptr_q + FPTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == FPTR_W'(MAX_PENDING - 1)) ? '0 : rd_ptr_q + FPTR_W'(1);
      // Read data with nothing outstanding cannot be routed; flag it until reset.
      if (s_readdatavalid && (fifo_cnt_q == '0)) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_cnt_q [NUM_MASTERS];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_MASTERS; i++) stat_cnt_q[i] <= '0;
    end else if (accept) begin
      stat_cnt_q[grant_q] <= stat_cnt_q[grant_q] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_stat
    assign grant_cnt[gi*16 +: 16] = stat_cnt_q[gi];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Directed bench for avmm_rr_arbiter: two masters, default widths, tag FIFO depth 8.
module tb_avmm_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MP = 8;

  logic              clk_clk;
  logic              reset_reset_n;
  logic [N*AW-1:0]   m_address;
  logic [N-1:0]      m_read;
  logic [N-1:0]      m_write;
  logic [N*DW-1:0]   m_writedata;
  logic [N*BW-1:0]   m_byteenable;
  logic [N-1:0]      m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic [N-1:0]      m_readdatavalid;
  logic [AW-1:0]     s_address;
  logic              s_read;
  logic              s_write;
  logic [DW-1:0]     s_writedata;
  logic [BW-1:0]     s_byteenable;
  logic              s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic              s_readdatavalid;
  logic              rsp_err;
  logic [N*16-1:0]   grant_cnt;

  int checks   = 0;
  int failures = 0;

  avmm_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .rsp_err(rsp_err), .grant_cnt(grant_cnt)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_address       = '0;
    m_read          = '0;
    m_write         = '0;
    m_writedata     = '0;
    m_byteenable    = '0;
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    clear_inputs();
    #3;
    checks++;
    if (m_waitrequest !== 2'b11) begin
      failures++; $display("FAIL reset_waitreq: got %b expected 11", m_waitrequest);
    end
    checks++;
    if ({s_read, s_write, m_readdatavalid, rsp_err} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes: got %b expected 00000", {s_read, s_write, m_readdatavalid, rsp_err});
    end
    checks++;
    if ({s_address, s_writedata, s_byteenable} !== '0 || grant_cnt !== '0) begin
      failures++; $display("FAIL reset_buses: got addr=%h wd=%h be=%h cnt=%h expected 0", s_address, s_writedata, s_byteenable, grant_cnt);
    end
    tick();
    tick();
    reset_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    m_address[AW-1:0]    = 24'h000010;
    m_writedata[DW-1:0]  = 32'hCAFEF00D;
    m_byteenable[BW-1:0] = 4'hF;
    m_write              = 2'b01;
    s_waitrequest        = 1'b0;
    #1;
    checks++;
    if ({s_write, m_waitrequest} !== 3'b011) begin
      failures++; $display("FAIL wr_cycle1: got s_write,waitreq=%b expected 011", {s_write, m_waitrequest});
    end
    tick();
    checks++;
    if ({s_write, s_read, m_waitrequest} !== 4'b1010) begin
      failures++; $display("FAIL wr_cycle2: got s_write,s_read,waitreq=%b expected 1010", {s_write, s_read, m_waitrequest});
    end
    checks++;
    if (s_address !== 24'h10 || s_writedata !== 32'hCAFEF00D || s_byteenable !== 4'hF) begin
      failures++; $display("FAIL wr_fields: got addr=%h wd=%h be=%h expected 000010 cafef00d f", s_address, s_writedata, s_byteenable);
    end
    tick();
    m_write = 2'b00;
    #1;
    checks++;
    if (s_write !== 1'b0 || m_waitrequest !== 2'b11) begin
      failures++; $display("FAIL wr_release: got s_write=%b waitreq=%b expected 0 11", s_write, m_waitrequest);
    end
  endtask

  // Rotation pointer now points at master 1 after the previous grant to master 0.
  task automatic test_slave_stall();
    m_address[2*AW-1:AW]   = 24'h000020;
    m_writedata[2*DW-1:DW] = 32'h12345678;
    m_byteenable[2*BW-1:BW] = 4'h3;
    m_write       = 2'b10;
    s_waitrequest = 1'b1;
    tick();
    checks++;
    if ({s_write, m_waitrequest} !== 3'b111 || s_address !== 24'h20 || s_writedata !== 32'h12345678 || s_byteenable !== 4'h3) begin
      failures++; $display("FAIL stall_grant: got s_write,waitreq=%b addr=%h wd=%h be=%h expected 111 000020 12345678 3", {s_write, m_waitrequest}, s_address, s_writedata, s_byteenable);
    end
    tick();
    checks++;
    if (s_write !== 1'b1) begin
      failures++; $display("FAIL stall_hold: got s_write=%b expected 1", s_write);
    end
    s_waitrequest = 1'b0;
    #1;
    checks++;
    if (m_waitrequest !== 2'b01) begin
      failures++; $display("FAIL stall_release: got waitreq=%b expected 01", m_waitrequest);
    end
    tick();
    m_write = 2'b00;
    #1;
    checks++;
    if (s_write !== 1'b0) begin
      failures++; $display("FAIL stall_done: got s_write=%b expected 0", s_write);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_wr;
    logic [AW-1:0] exp_addr;
    do_reset();
    m_address[AW-1:0]    = 24'h000100;
    m_address[2*AW-1:AW] = 24'h000200;
    m_write = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_wr   = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 0) ? 24'h000100 : 24'h000200;
      checks++;
      if (m_waitrequest !== exp_wr || s_address !== exp_addr || s_write !== 1'b1) begin
        failures++; $display("FAIL rr_grant%0d: got waitreq=%b addr=%h s_write=%b expected %b %h 1", i, m_waitrequest, s_address, s_write, exp_wr, exp_addr);
      end
      tick();
      checks++;
      if (m_waitrequest !== 2'b11) begin
        failures++; $display("FAIL rr_bubble%0d: got waitreq=%b expected 11", i, m_waitrequest);
      end
    end
    m_write = 2'b00;
    tick();
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_address[2*AW-1:AW] = 24'h000300;
    m_read = 2'b10;
    for (int i = 0; i < MP; i++) begin
      tick();
      checks++;
      if ({s_read, m_waitrequest} !== 3'b101) begin
        failures++; $display("FAIL full_read%0d: got s_read,waitreq=%b expected 101", i, {s_read, m_waitrequest});
      end
      tick();
    end
    tick();
    checks++;
    if ({s_read, s_write, m_waitrequest} !== 4'b0011) begin
      failures++; $display("FAIL full_stall9: got s_read,s_write,waitreq=%b expected 0011", {s_read, s_write, m_waitrequest});
    end
    m_address[AW-1:0] = 24'h000040;
    m_write = 2'b01;
    tick();
    checks++;
    if ({s_read, s_write, m_waitrequest} !== 4'b0110 || s_address !== 24'h40) begin
      failures++; $display("FAIL full_write_grant: got s_read,s_write,waitreq=%b addr=%h expected 0110 000040", {s_read, s_write, m_waitrequest}, s_address);
    end
    tick();
    m_read  = 2'b00;
    m_write = 2'b00;
    for (int i = 0; i < MP; i++) begin
      s_readdatavalid = 1'b1;
      s_readdata      = 32'hD0000000 + i;
      #1;
      checks++;
      if (m_readdatavalid !== 2'b10 || m_readdata !== 32'hD0000000 + i) begin
        failures++; $display("FAIL drain%0d: got rdv=%b data=%h expected 10 %h", i, m_readdatavalid, m_readdata, 32'hD0000000 + i);
      end
      tick();
    end
    s_readdatavalid = 1'b0;
    #1;
    checks++;
    if (rsp_err !== 1'b0 || m_readdatavalid !== 2'b00) begin
      failures++; $display("FAIL drain_end: got rsp_err=%b rdv=%b expected 0 00", rsp_err, m_readdatavalid);
    end
  endtask

  task automatic test_interleaved_reads();
    logic [DW-1:0] rdat [3];
    logic [1:0]    rexp [3];
    do_reset();
    m_address[AW-1:0]    = 24'h000500;
    m_address[2*AW-1:AW] = 24'h000600;
    rexp[0] = 2'b01; rexp[1] = 2'b10; rexp[2] = 2'b01;
    rdat[0] = 32'hAAAA0001; rdat[1] = 32'hBBBB0002; rdat[2] = 32'hCCCC0003;
    for (int i = 0; i < 3; i++) begin
      m_read = rexp[i];
      tick();
      checks++;
      if ({s_read, m_waitrequest} !== {1'b1, ~rexp[i]} || s_address !== ((i == 1) ? 24'h000600 : 24'h000500)) begin
        failures++; $display("FAIL il_issue%0d: got s_read,waitreq=%b addr=%h expected %b", i, {s_read, m_waitrequest}, s_address, {1'b1, ~rexp[i]});
      end
      tick();
    end
    m_read = 2'b00;
    for (int i = 0; i < 3; i++) begin
      s_readdatavalid = 1'b1;
      s_readdata      = rdat[i];
      #1;
      checks++;
      if (m_readdatavalid !== rexp[i] || m_readdata !== rdat[i]) begin
        failures++; $display("FAIL il_return%0d: got rdv=%b data=%h expected %b %h", i, m_readdatavalid, m_readdata, rexp[i], rdat[i]);
      end
      tick();
    end
    s_readdatavalid = 1'b0;
    #1;
    checks++;
    if (rsp_err !== 1'b0) begin
      failures++; $display("FAIL il_rsp_err: got %b expected 0", rsp_err);
    end
  endtask

  task automatic test_empty_return();
    do_reset();
    s_readdatavalid = 1'b1;
    s_readdata      = 32'h0000005A;
    #1;
    checks++;
    if (m_readdatavalid !== 2'b00 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL empty_strobe: got rdv=%b rsp_err=%b expected 00 0", m_readdatavalid, rsp_err);
    end
    tick();
    s_readdatavalid = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_err !== 1'b1) begin
      failures++; $display("FAIL empty_sticky: got rsp_err=%b expected 1", rsp_err);
    end
    do_reset();
    checks++;
    if (rsp_err !== 1'b0) begin
      failures++; $display("FAIL empty_cleared: got rsp_err=%b expected 0", rsp_err);
    end
  endtask

  task automatic test_stats();
    logic [N*16-1:0] exp_cnt;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      m_write = (j < 3) ? 2'b01 : 2'b10;
      tick();
      tick();
      m_write = 2'b00;
    end
    #1;
`ifdef ARB_STATS_EN
    exp_cnt = {16'd1, 16'd3};
`else
    exp_cnt = '0;
`endif
    checks++;
    if (grant_cnt !== exp_cnt) begin
      failures++; $display("FAIL stats: got grant_cnt=%h expected %h", grant_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_read = 2'b01;
    tick();
    tick();
    m_read        = 2'b00;
    m_write       = 2'b10;
    s_waitrequest = 1'b1;
    tick();
    checks++;
    if ({s_write, m_waitrequest} !== 3'b111) begin
      failures++; $display("FAIL mid_busy: got s_write,waitreq=%b expected 111", {s_write, m_waitrequest});
    end
    #2;
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if ({s_read, s_write, m_waitrequest, m_readdatavalid, rsp_err} !== 7'b0011000 || s_address !== '0 || grant_cnt !== '0) begin
      failures++; $display("FAIL mid_async: got %b addr=%h cnt=%h expected 0011000 0 0", {s_read, s_write, m_waitrequest, m_readdatavalid, rsp_err}, s_address, grant_cnt);
    end
    m_write       = 2'b00;
    s_waitrequest = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    tick();
    s_readdatavalid = 1'b1;
    #1;
    checks++;
    if (m_readdatavalid !== 2'b00) begin
      failures++; $display("FAIL mid_tags_lost: got rdv=%b expected 00", m_readdatavalid);
    end
    tick();
    s_readdatavalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_slave_stall();
    test_round_robin();
    test_fifo_full();
    test_interleaved_reads();
    test_empty_return();
    test_stats();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
